// File: rtl/uart_boot_loader_if.sv
// Instruction RAM write bus driven by the boot loader.
// Single-cycle write strobe; no backpressure, the RAM accepts every write.
interface uart_boot_loader_if #(
    parameter int ADDR_W = 10
) ();
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [31:0]       mem_wdata;

    modport master (output mem_we, output mem_addr, output mem_wdata);
    modport slave  (input  mem_we, input  mem_addr, input  mem_wdata);
endinterface

// File: rtl/uart_boot_loader.sv
// UART 8N1 boot loader: frames A5/LEN/data/XOR-checksum into instruction RAM writes.
// Write lands one cycle after the 4th byte of a word; no backpressure, RAM always accepts.
module uart_boot_loader #(
    parameter int CLKS_PER_BIT = 104,
    parameter int ADDR_W       = 10,
    parameter int MAX_WORDS    = 1024
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       uart_rx,
    uart_boot_loader_if.master         mem,
    output logic                       core_rst,
    output logic                       done,
    output logic                       err,
    output logic                       frame_err
);
    localparam int CNT_W = $clog2(CLKS_PER_BIT);
    localparam logic [CNT_W-1:0] HALF_M1 = CNT_W'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CNT_W-1:0] FULL_M1 = CNT_W'(CLKS_PER_BIT - 1);

    typedef enum logic [2:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP, RX_WAIT} rx_state_t;
    typedef enum logic [2:0] {IDLE, LEN_LO, LEN_HI, DATA, CSUM, DONE, ERROR} state_t;

    rx_state_t         rx_st;
    logic              rx_s1, rx_s2, rx_prev;
    logic [CNT_W-1:0]  cnt;
    logic [2:0]        bit_idx;
    logic [7:0]        shift;
    logic              byte_vld;
    logic [7:0]        rx_byte;

    state_t            st;
    logic [7:0]        len_lo;
    logic [15:0]       len;
    logic [7:0]        csum;
    logic [ADDR_W-1:0] word_idx;
    logic [1:0]        lane;
    logic [7:0]        b0, b1, b2;

    // Receiver: sample mid-bit, drop bytes with a bad stop bit and wait for idle line.
    always_ff @(posedge clk) begin
        if (rst) begin
            rx_s1     <= 1'b1;
            rx_s2     <= 1'b1;
            rx_prev   <= 1'b1;
            rx_st     <= RX_IDLE;
            cnt       <= '0;
            bit_idx   <= '0;
            shift     <= '0;
            byte_vld  <= 1'b0;
            rx_byte   <= '0;
            frame_err <= 1'b0;
        end else begin
            rx_s1    <= uart_rx;
            rx_s2    <= rx_s1;
            rx_prev  <= rx_s2;
            byte_vld <= 1'b0;
            case (rx_st)
                RX_IDLE: begin
                    if (rx_prev && !rx_s2) begin
                        rx_st <= RX_START;
                        cnt   <= '0;
                    end
                end
                RX_START: begin
                    if (cnt == HALF_M1) begin
                        cnt     <= '0;
                        bit_idx <= '0;
                        rx_st   <= rx_s2 ? RX_IDLE : RX_DATA;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                RX_DATA: begin
                    if (cnt == FULL_M1) begin
                        cnt     <= '0;
                        shift   <= {rx_s2, shift[7:1]};
                        bit_idx <= bit_idx + 3'd1;
                        if (bit_idx == 3'd7) rx_st <= RX_STOP;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                RX_STOP: begin
                    if (cnt == FULL_M1) begin
                        cnt <= '0;
                        if (rx_s2) begin
                            byte_vld <= 1'b1;
                            rx_byte  <= shift;
                            rx_st    <= RX_IDLE;
                        end else begin
                            frame_err <= 1'b1;
                            rx_st     <= RX_WAIT;
                        end
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                RX_WAIT: begin
                    if (rx_s2) rx_st <= RX_IDLE;
                end
                default: rx_st <= RX_IDLE;
            endcase
        end
    end

    // Frame parser and RAM writer; DONE is terminal until reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            st            <= IDLE;
            mem.mem_we    <= 1'b0;
            mem.mem_addr  <= '0;
            mem.mem_wdata <= '0;
            core_rst      <= 1'b1;
            done          <= 1'b0;
            err           <= 1'b0;
            len_lo        <= '0;
            len           <= '0;
            csum          <= '0;
            word_idx      <= '0;
            lane          <= '0;
            b0            <= '0;
            b1            <= '0;
            b2            <= '0;
        end else begin
            mem.mem_we <= 1'b0;
            if (byte_vld) begin
                case (st)
                    IDLE, ERROR: begin
                        if (rx_byte == 8'hA5) begin
                            st       <= LEN_LO;
                            err      <= 1'b0;
                            csum     <= '0;
                            word_idx <= '0;
                            lane     <= '0;
                        end
                    end
                    LEN_LO: begin
                        len_lo <= rx_byte;
                        st     <= LEN_HI;
                    end
                    LEN_HI: begin
                        len <= {rx_byte, len_lo};
                        if ({16'd0, rx_byte, len_lo} > 32'(MAX_WORDS)) begin
                            st       <= ERROR;
                            err      <= 1'b1;
                            core_rst <= 1'b1;
                            done     <= 1'b0;
                        end else if ({rx_byte, len_lo} == 16'd0) begin
                            st <= CSUM;
                        end else begin
                            st <= DATA;
                        end
                    end
                    DATA: begin
                        csum <= csum ^ rx_byte;
                        lane <= lane + 2'd1;
                        case (lane)
                            2'd0: b0 <= rx_byte;
                            2'd1: b1 <= rx_byte;
                            2'd2: b2 <= rx_byte;
                            default: begin
                                mem.mem_we    <= 1'b1;
                                mem.mem_addr  <= word_idx;
                                mem.mem_wdata <= {rx_byte, b2, b1, b0};
                                word_idx      <= word_idx + ADDR_W'(1);
                                if (16'(word_idx) == len - 16'd1) st <= CSUM;
                            end
                        endcase
                    end
                    CSUM: begin
                        if (rx_byte == csum) begin
                            st       <= DONE;
                            done     <= 1'b1;
                            core_rst <= 1'b0;
                        end else begin
                            st       <= ERROR;
                            err      <= 1'b1;
                            core_rst <= 1'b1;
                            done     <= 1'b0;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_uart_boot_loader.sv
// Directed bench for uart_boot_loader at 4 clocks per UART bit.
module tb_uart_boot_loader;
    logic clk = 1'b0;
    logic rst = 1'b1;
    logic uart_rx = 1'b1;
    logic core_rst, done, err, frame_err;

    uart_boot_loader_if #(.ADDR_W(10)) mem_if ();

    uart_boot_loader #(.CLKS_PER_BIT(4), .ADDR_W(10), .MAX_WORDS(1024)) dut (
        .clk(clk), .rst(rst), .uart_rx(uart_rx), .mem(mem_if),
        .core_rst(core_rst), .done(done), .err(err), .frame_err(frame_err)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int wr_n = 0;
    int dbl = 0;
    logic prev_we = 1'b0;
    logic [9:0]  wr_addr [0:63];
    logic [31:0] wr_data [0:63];

    always @(posedge clk) begin
        #1;
        if (mem_if.mem_we === 1'b1) begin
            if (wr_n < 64) begin
                wr_addr[wr_n] = mem_if.mem_addr;
                wr_data[wr_n] = mem_if.mem_wdata;
            end
            wr_n++;
            if (prev_we) dbl++;
        end
        prev_we = (mem_if.mem_we === 1'b1);
    end

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic send_byte(input logic [7:0] b, input logic stop);
        uart_rx = 1'b0;
        repeat (4) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            uart_rx = b[i];
            repeat (4) @(negedge clk);
        end
        uart_rx = stop;
        repeat (4) @(negedge clk);
        uart_rx = 1'b1;
        if (!stop) repeat (4) @(negedge clk);
    endtask

    task automatic send_body(input logic [7:0] cs);
        send_byte(8'h02, 1); send_byte(8'h00, 1);
        send_byte(8'h13, 1); send_byte(8'h00, 1); send_byte(8'h00, 1); send_byte(8'h00, 1);
        send_byte(8'hEF, 1); send_byte(8'hBE, 1); send_byte(8'hAD, 1); send_byte(8'hDE, 1);
        send_byte(cs, 1);
        idle(10);
    endtask

    task automatic send_good(input logic [7:0] cs);
        send_byte(8'hA5, 1);
        send_body(cs);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        idle(2);
        rst = 1'b0;
        idle(2);
    endtask

    task automatic test_reset();
        idle(3);
        checks++; if (mem_if.mem_we !== 1'b0) begin errors++; $display("FAIL reset_we got %0b want 0", mem_if.mem_we); end
        checks++; if (mem_if.mem_addr !== 10'd0) begin errors++; $display("FAIL reset_addr got %0h want 0", mem_if.mem_addr); end
        checks++; if (mem_if.mem_wdata !== 32'd0) begin errors++; $display("FAIL reset_wdata got %0h want 0", mem_if.mem_wdata); end
        checks++; if (core_rst !== 1'b1) begin errors++; $display("FAIL reset_core_rst got %0b want 1", core_rst); end
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done got %0b want 0", done); end
        checks++; if (err !== 1'b0) begin errors++; $display("FAIL reset_err got %0b want 0", err); end
        checks++; if (frame_err !== 1'b0) begin errors++; $display("FAIL reset_frame_err got %0b want 0", frame_err); end
        rst = 1'b0;
        idle(2);
    endtask

    task automatic test_good_load();
        int base;
        do_reset();
        base = wr_n;
        send_byte(8'hA5, 1);
        send_byte(8'h02, 1); send_byte(8'h00, 1);
        send_byte(8'h13, 1); send_byte(8'h00, 1); send_byte(8'h00, 1); send_byte(8'h00, 1);
        idle(4);
        checks++; if (core_rst !== 1'b1 || done !== 1'b0) begin errors++; $display("FAIL good_midload got core_rst=%0b done=%0b want 1/0", core_rst, done); end
        send_byte(8'hEF, 1); send_byte(8'hBE, 1); send_byte(8'hAD, 1); send_byte(8'hDE, 1);
        send_byte(8'h31, 1);
        idle(10);
        checks++; if (wr_n - base !== 2) begin errors++; $display("FAIL good_writes got %0d want 2", wr_n - base); end
        checks++; if (wr_addr[base] !== 10'd0 || wr_data[base] !== 32'h00000013) begin errors++; $display("FAIL good_word0 got %0h=%0h want 0=13", wr_addr[base], wr_data[base]); end
        checks++; if (wr_addr[base+1] !== 10'd1 || wr_data[base+1] !== 32'hDEADBEEF) begin errors++; $display("FAIL good_word1 got %0h=%0h want 1=deadbeef", wr_addr[base+1], wr_data[base+1]); end
        checks++; if (done !== 1'b1) begin errors++; $display("FAIL good_done got %0b want 1", done); end
        checks++; if (core_rst !== 1'b0) begin errors++; $display("FAIL good_core_rst got %0b want 0", core_rst); end
        checks++; if (err !== 1'b0) begin errors++; $display("FAIL good_err got %0b want 0", err); end
        checks++; if (mem_if.mem_we !== 1'b0 || mem_if.mem_wdata !== 32'hDEADBEEF) begin errors++; $display("FAIL good_hold got we=%0b wdata=%0h want 0/deadbeef", mem_if.mem_we, mem_if.mem_wdata); end
    endtask

    task automatic test_bad_csum_retry();
        int base;
        do_reset();
        send_good(8'h30);
        checks++; if (err !== 1'b1) begin errors++; $display("FAIL badcs_err got %0b want 1", err); end
        checks++; if (core_rst !== 1'b1 || done !== 1'b0) begin errors++; $display("FAIL badcs_core got core_rst=%0b done=%0b want 1/0", core_rst, done); end
        send_byte(8'hA5, 1);
        idle(6);
        checks++; if (err !== 1'b0) begin errors++; $display("FAIL retry_err_clear got %0b want 0", err); end
        base = wr_n;
        send_body(8'h31);
        checks++; if (wr_n - base !== 2) begin errors++; $display("FAIL retry_writes got %0d want 2", wr_n - base); end
        checks++; if (wr_addr[base] !== 10'd0 || wr_data[base+1] !== 32'hDEADBEEF) begin errors++; $display("FAIL retry_data got %0h/%0h want 0/deadbeef", wr_addr[base], wr_data[base+1]); end
        checks++; if (done !== 1'b1 || core_rst !== 1'b0 || err !== 1'b0) begin errors++; $display("FAIL retry_done got done=%0b core_rst=%0b err=%0b want 1/0/0", done, core_rst, err); end
    endtask

    task automatic test_len_limits();
        int base;
        do_reset();
        base = wr_n;
        send_byte(8'hA5, 1); send_byte(8'h00, 1); send_byte(8'h00, 1); send_byte(8'h00, 1);
        idle(10);
        checks++; if (wr_n - base !== 0) begin errors++; $display("FAIL len0_writes got %0d want 0", wr_n - base); end
        checks++; if (done !== 1'b1 || core_rst !== 1'b0) begin errors++; $display("FAIL len0_done got done=%0b core_rst=%0b want 1/0", done, core_rst); end
        do_reset();
        base = wr_n;
        send_byte(8'hA5, 1); send_byte(8'h01, 1); send_byte(8'h04, 1);
        idle(10);
        checks++; if (err !== 1'b1 || core_rst !== 1'b1 || done !== 1'b0) begin errors++; $display("FAIL lenmax_err got err=%0b core_rst=%0b done=%0b want 1/1/0", err, core_rst, done); end
        checks++; if (wr_n - base !== 0) begin errors++; $display("FAIL lenmax_writes got %0d want 0", wr_n - base); end
    endtask

    task automatic test_line_faults();
        int base;
        do_reset();
        base = wr_n;
        send_byte(8'hA5, 1);
        uart_rx = 1'b0;
        @(negedge clk);
        uart_rx = 1'b1;
        idle(20);
        checks++; if (frame_err !== 1'b0) begin errors++; $display("FAIL glitch_frame_err got %0b want 0", frame_err); end
        send_byte(8'h02, 0);
        idle(6);
        checks++; if (frame_err !== 1'b1) begin errors++; $display("FAIL stop0_frame_err got %0b want 1", frame_err); end
        send_byte(8'h00, 1); send_byte(8'h00, 1); send_byte(8'h00, 1);
        idle(10);
        checks++; if (done !== 1'b1 || err !== 1'b0) begin errors++; $display("FAIL fault_state got done=%0b err=%0b want 1/0", done, err); end
        checks++; if (frame_err !== 1'b1 || wr_n - base !== 0) begin errors++; $display("FAIL fault_sticky got frame_err=%0b writes=%0d want 1/0", frame_err, wr_n - base); end
    endtask

    task automatic test_garbage();
        int base;
        do_reset();
        send_byte(8'h55, 1); send_byte(8'h13, 1);
        idle(6);
        checks++; if (done !== 1'b0 || err !== 1'b0) begin errors++; $display("FAIL garbage_state got done=%0b err=%0b want 0/0", done, err); end
        base = wr_n;
        send_good(8'h31);
        checks++; if (wr_n - base !== 2 || wr_data[base] !== 32'h00000013) begin errors++; $display("FAIL garbage_load got writes=%0d d0=%0h want 2/13", wr_n - base, wr_data[base]); end
        checks++; if (done !== 1'b1 || core_rst !== 1'b0) begin errors++; $display("FAIL garbage_done got done=%0b core_rst=%0b want 1/0", done, core_rst); end
    endtask

    task automatic test_reset_mid_load();
        int base;
        int w1;
        do_reset();
        base = wr_n;
        send_byte(8'hA5, 1); send_byte(8'h02, 1); send_byte(8'h00, 1);
        send_byte(8'h13, 1); send_byte(8'h00, 1); send_byte(8'h00, 1); send_byte(8'h00, 1);
        send_byte(8'hEF, 1);
        idle(4);
        checks++; if (wr_n - base !== 1) begin errors++; $display("FAIL midrst_pre_writes got %0d want 1", wr_n - base); end
        rst = 1'b1;
        @(posedge clk);
        #1;
        checks++; if (mem_if.mem_we !== 1'b0 || mem_if.mem_addr !== 10'd0 || mem_if.mem_wdata !== 32'd0) begin errors++; $display("FAIL midrst_bus got we=%0b addr=%0h wdata=%0h want 0/0/0", mem_if.mem_we, mem_if.mem_addr, mem_if.mem_wdata); end
        checks++; if (core_rst !== 1'b1 || done !== 1'b0 || err !== 1'b0 || frame_err !== 1'b0) begin errors++; $display("FAIL midrst_status got %0b%0b%0b%0b want 1000", core_rst, done, err, frame_err); end
        w1 = wr_n;
        idle(3);
        rst = 1'b0;
        idle(20);
        checks++; if (wr_n !== w1) begin errors++; $display("FAIL midrst_no_write got %0d want %0d", wr_n, w1); end
        base = wr_n;
        send_good(8'h31);
        checks++; if (wr_n - base !== 2 || wr_addr[base] !== 10'd0 || wr_addr[base+1] !== 10'd1) begin errors++; $display("FAIL midrst_reload got writes=%0d a0=%0h a1=%0h want 2/0/1", wr_n - base, wr_addr[base], wr_addr[base+1]); end
        checks++; if (done !== 1'b1 || core_rst !== 1'b0) begin errors++; $display("FAIL midrst_done got done=%0b core_rst=%0b want 1/0", done, core_rst); end
    endtask

    task automatic test_post_done();
        int base;
        do_reset();
        send_good(8'h31);
        base = wr_n;
        send_byte(8'hA5, 1); send_byte(8'h01, 1); send_byte(8'h00, 1);
        send_byte(8'h13, 1); send_byte(8'h00, 1); send_byte(8'h00, 1); send_byte(8'h00, 1);
        send_byte(8'h13, 1);
        idle(10);
        checks++; if (wr_n - base !== 0) begin errors++; $display("FAIL postdone_writes got %0d want 0", wr_n - base); end
        checks++; if (done !== 1'b1 || core_rst !== 1'b0 || err !== 1'b0) begin errors++; $display("FAIL postdone_state got done=%0b core_rst=%0b err=%0b want 1/0/0", done, core_rst, err); end
    endtask

    task automatic test_back_to_back();
        checks++; if (dbl !== 0) begin errors++; $display("FAIL we_consecutive got %0d want 0", dbl); end
    endtask

    initial begin
        test_reset();
        test_good_load();
        test_bad_csum_retry();
        test_len_limits();
        test_line_faults();
        test_garbage();
        test_reset_mid_load();
        test_post_done();
        test_back_to_back();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/uart_boot_loader.md
Name: uart_boot_loader

Overview:
Serial boot loader upstream of the rv32i_core instruction RAM. It receives a framed program image on one UART pin, assembles 32-bit little-endian words and writes them sequentially into the instruction memory write port. It holds the core in reset until the image is loaded and its checksum verifies, then releases it.

Parameters:
CLKS_PER_BIT, 104, clk cycles per UART bit; must be >= 4.
ADDR_W, 10, word-address width of the instruction RAM.
MAX_WORDS, 1024, largest accepted image length in words; must be <= 2**ADDR_W.

Ports:
clk  in  1  system clock
rst  in  1  synchronous, active-high reset
uart_rx  in  1  asynchronous serial input, idle high, 8N1, LSB first
mem_we  out  1  one-cycle instruction RAM write strobe
mem_addr  out  ADDR_W  word address of the write
mem_wdata  out  32  write data
core_rst  out  1  reset to rv32i_core, high until load succeeds
done  out  1  image loaded and verified
err  out  1  length or checksum error on the current attempt
frame_err  out  1  sticky: a byte was received with stop bit = 0

Behaviour:
- Reset values: mem_we=0, mem_addr=0, mem_wdata=0, core_rst=1, done=0, err=0, frame_err=0. All state returns to IDLE and receiver idle. Reset mid-load aborts the load; no further writes occur.
- RX front end: uart_rx passes through 2-flop synchronizer (line assumed high at reset).
- Start: falling edge of the synced line while the receiver is idle. After CLKS_PER_BIT/2 cycles, the line is re-sampled. If it is high, this is a false start and the receiver returns to idle.
- Data: 8 bits, each sampled every CLKS_PER_BIT cycles thereafter, LSB first. The stop bit is sampled one interval after bit 7.
- Stop bit = 1: byte_valid pulses for 1 cycle in that cycle. Stop bit = 0: byte discarded, frame_err set (cleared only by rst). The receiver waits for the line to go high before it arms for the next start.
- Protocol: sync byte 0xA5, then LEN_LO, then LEN_HI (16-bit word count), then LEN×4 data bytes (little-endian per word), then CSUM = XOR of all data bytes.
- FSM states: IDLE, LEN_LO, LEN_HI, DATA, CSUM, DONE, ERROR.
  - IDLE: bytes other than 0xA5 are ignored. 0xA5 goes to LEN_LO and clears err, the checksum accumulator, the word index and the byte lane.
  - LEN_LO: latch the low byte, go to LEN_HI.
  - LEN_HI: if LEN > MAX_WORDS, go to ERROR. If LEN = 0, go to CSUM. Otherwise go to DATA.
  - DATA: each byte XORs into the accumulator and fills lane 0..3. On lane 3, the next cycle drives mem_we=1, mem_addr=word index, mem_wdata={b3,b2,b1,b0}; then the word index is incremented. After word LEN-1 is written, go to CSUM.
  - CSUM: if the byte equals the accumulator, go to DONE. Otherwise go to ERROR.
  - DONE: done=1, core_rst=0 from the cycle after the CSUM byte_valid. All further RX input is ignored until rst.
  - ERROR: err=1, core_rst=1, done=0. Receiving 0xA5 restarts at LEN_LO and clears err. Other bytes are ignored.
- mem_we is never high for more than 1 consecutive cycle. mem_addr and mem_wdata hold their last values when mem_we=0. The word index never exceeds LEN-1, so there is no wrap.
- core_rst is registered and deasserts only on the DONE transition.
- A new byte cannot arrive within 1 cycle of the previous one, so there is no simultaneous byte/write conflict.

Test Plan:
(Bench uses CLKS_PER_BIT=4, ADDR_W=10, MAX_WORDS=1024.)
- Good load: send A5 02 00 13 00 00 00 EF BE AD DE 31 -> writes addr0=0x00000013, addr1=0xDEADBEEF, exactly 2 mem_we pulses; then done=1, core_rst=0, err=0.
- Bad checksum then retry: same frame with CSUM=0x30 -> err=1, core_rst=1, done=0. Resend the correct frame -> err clears on A5, 2 writes, done=1.
- Length limits: A5 00 00 00 -> no writes, done=1. A5 01 04 -> err=1 after LEN_HI, no writes.
- Line faults: 1-cycle low glitch -> no byte, state unchanged. Byte with stop=0 -> frame_err=1, byte dropped, FSM state unchanged. Garbage 0x55 0x13 before A5 -> ignored, and the following good load succeeds.
- Reset mid-load: assert rst after 5 data bytes -> next cycle all outputs at reset values, no mem_we. The subsequent full good load succeeds from addr 0.
- Post-done: after done, send A5 01 00 ... -> no writes, done stays 1, core_rst stays 0.
